fx2_rotsh_pipe: RTL and testbench



---
 rtl/fx2_pkg.sv | 22 ++
 rtl/fx2_lane_shift.sv | 43 ++++
 rtl/fx2_rotsh_pipe.sv | 90 +++++++++
 tb/tb_fx2_rotsh_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 rotate/shift pipe: mode encodings,
// default geometry and the lane-count helper.
package fx2_pkg;

    typedef enum logic [1:0] {
        MODE_ROT  = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_SHRA = 2'b11
    } fx2_mode_e;

    localparam int FX2_ELEM_W = 32;
    localparam int FX2_VEC_W  = 128;
    localparam int FX2_TAG_W  = 7;
    localparam int FX2_STAGES = 2;

    // Number of count bits that address a position inside a lane.
    function automatic int fx2_log2(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fx2_lane_shift.sv
// One lane of the FX2 rotate/shift unit, purely combinational.
// Bit 0 of data is the MSB, so "left" moves bits toward index 0.
// count carries L+1 bits: the top bit flags a count of ELEM_W or more.
module fx2_lane_shift
    import fx2_pkg::*;
#(
    parameter int ELEM_W = FX2_ELEM_W
) (
    input  logic [0:ELEM_W-1]         data,
    input  logic [$clog2(ELEM_W):0]   count,
    input  logic [1:0]                mode,
    output logic [0:ELEM_W-1]         result
);

    localparam int L = fx2_log2(ELEM_W);

    logic [ELEM_W-1:0]   v;
    logic [ELEM_W-1:0]   res;
    logic [2*ELEM_W-1:0] dbl;
    logic [L-1:0]        amt;
    logic                big;
    fx2_mode_e           op;

    assign v      = data;
    assign op     = fx2_mode_e'(mode);
    assign result = res;

    // Select the lane operation; rotate ignores the overflow bit, shifts saturate on it.
    always_comb begin
        amt = count[L-1:0];
        big = count[L];
        dbl = {v, v} << amt;
        res = v;
        case (op)
            MODE_ROT:  res = dbl[2*ELEM_W-1:ELEM_W];
            MODE_SHL:  res = big ? '0 : (v << amt);
            MODE_SHR:  res = big ? '0 : (v >> amt);
            MODE_SHRA: res = big ? {ELEM_W{v[ELEM_W-1]}} : $unsigned($signed(v) >>> amt);
            default:   res = v;
        endcase
    end

endmodule

// File: rtl/fx2_rotsh_pipe.sv
// FX2 pipelined per-lane rotate/shift unit with tag, stall and flush.
// Optional immediate count is enabled by defining FX2_ROTSH_IMM_EN.
// The operation is computed on the input side; STAGES registers follow.
module fx2_rotsh_pipe
    import fx2_pkg::*;
#(
    parameter int VEC_W  = FX2_VEC_W,
    parameter int ELEM_W = FX2_ELEM_W,
    parameter int STAGES = FX2_STAGES,
    parameter int TAG_W  = FX2_TAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [1:0]                in_mode,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [0:VEC_W-1]          ra,
    input  logic [0:VEC_W-1]          rb,
    input  logic                      stall,
    input  logic                      flush,
`ifdef FX2_ROTSH_IMM_EN
    input  logic                      in_use_imm,
    input  logic [$clog2(ELEM_W):0]   in_imm,
`endif
    output logic                      out_valid,
    output logic [TAG_W-1:0]          out_tag,
    output logic [0:VEC_W-1]          result
);

    localparam int LANES = VEC_W / ELEM_W;
    localparam int L     = fx2_log2(ELEM_W);

    logic [0:VEC_W-1] comp_data;
    logic             unused_rb_bits;

    // Only the low L+1 bits of each rb lane are meaningful counts.
    assign unused_rb_bits = ^rb;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [L:0] cnt;
`ifdef FX2_ROTSH_IMM_EN
        assign cnt = in_use_imm ? in_imm : rb[i*ELEM_W + ELEM_W-1-L +: L+1];
`else
        assign cnt = rb[i*ELEM_W + ELEM_W-1-L +: L+1];
`endif
        fx2_lane_shift #(.ELEM_W(ELEM_W)) u_lane (
            .data   (ra[i*ELEM_W +: ELEM_W]),
            .count  (cnt),
            .mode   (in_mode),
            .result (comp_data[i*ELEM_W +: ELEM_W])
        );
    end

    logic             valid_q [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [0:VEC_W-1] data_q  [STAGES];

    // Advance the pipe; flush kills valids, stall freezes, data/tag load only behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                tag_q[0]  <= in_tag;
                data_q[0] <= comp_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    tag_q[s]  <= tag_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign result    = data_q[STAGES-1];

endmodule

// File: tb/tb_fx2_rotsh_pipe.sv
// Self-checking bench for fx2_rotsh_pipe: directed cases from the block's
// behaviour plus randomized traffic checked against a bit-level lane model
// and a due-time scoreboard. A second instance covers ELEM_W=16, STAGES=1.
// Defining FX2_ROTSH_IMM_EN adds an immediate-count case.
module tb_fx2_rotsh_pipe;

    localparam int VEC_W  = 128;
    localparam int ELEM_W = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       in_mode = 2'b00;
    logic [TAG_W-1:0] in_tag = '0;
    logic [0:VEC_W-1] ra = '0;
    logic [0:VEC_W-1] rb = '0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [0:VEC_W-1] result;
`ifdef FX2_ROTSH_IMM_EN
    logic             in_use_imm = 1'b0;
    logic [5:0]       in_imm = '0;
`endif

    logic             v2 = 1'b0;
    logic [1:0]       m2 = 2'b00;
    logic [TAG_W-1:0] t2 = '0;
    logic [0:63]      ra2 = '0;
    logic [0:63]      rb2 = '0;
    logic             stall2 = 1'b0;
    logic             flush2 = 1'b0;
    logic             out_valid2;
    logic [TAG_W-1:0] out_tag2;
    logic [0:63]      result2;
`ifdef FX2_ROTSH_IMM_EN
    logic             use_imm2 = 1'b0;
    logic [4:0]       imm2 = '0;
`endif

    always #5 clk = ~clk;

    fx2_rotsh_pipe #(.VEC_W(VEC_W), .ELEM_W(ELEM_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode), .in_tag(in_tag),
        .ra(ra), .rb(rb), .stall(stall), .flush(flush),
`ifdef FX2_ROTSH_IMM_EN
        .in_use_imm(in_use_imm), .in_imm(in_imm),
`endif
        .out_valid(out_valid), .out_tag(out_tag), .result(result)
    );

    fx2_rotsh_pipe #(.VEC_W(64), .ELEM_W(16), .STAGES(1), .TAG_W(TAG_W)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_mode(m2), .in_tag(t2),
        .ra(ra2), .rb(rb2), .stall(stall2), .flush(flush2),
`ifdef FX2_ROTSH_IMM_EN
        .in_use_imm(use_imm2), .in_imm(imm2),
`endif
        .out_valid(out_valid2), .out_tag(out_tag2), .result(result2)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [0:127]     data;
        int               due;
    } op_t;

    op_t              q[$];
    int               adv;
    logic             prev_valid;
    logic [TAG_W-1:0] last_tag;
    logic [0:127]     last_res;
    int               checks;
    int               errors;
    int               tag9_seen;
    int               tag5_seen;
    logic [0:127]     exp_bound [1:3];

    // Spec-level lane model: each result bit picks its source bit by the mode's index rule.
    function automatic logic [0:127] refModel(input logic [0:127] a, input logic [0:127] b,
                                              input logic [1:0] mode, input int ew, input int vw);
        logic [0:127] r;
        int lb;
        int base;
        int c;
        r  = '0;
        lb = 0;
        while ((1 << lb) < ew) lb++;
        for (int lane = 0; lane < vw / ew; lane++) begin
            base = lane * ew;
            c = 0;
            for (int k = 0; k <= lb; k++)
                if (b[base + ew - 1 - k]) c += (1 << k);
            for (int bi = 0; bi < ew; bi++) begin
                case (mode)
                    2'b00:   r[base+bi] = a[base + (bi + c) % ew];
                    2'b01:   r[base+bi] = (bi + c < ew) ? a[base+bi+c] : 1'b0;
                    2'b10:   r[base+bi] = (bi >= c) ? a[base+bi-c] : 1'b0;
                    default: r[base+bi] = (bi >= c) ? a[base+bi-c] : a[base];
                endcase
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, update the scoreboard for that edge, then check outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [TAG_W-1:0] t,
                                 input logic [0:127] a, input logic [0:127] b,
                                 input logic st, input logic fl);
        logic exp_v;
        in_valid = v; in_mode = m; in_tag = t; ra = a; rb = b; stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            exp_v = 1'b0;
        end else if (st) begin
            exp_v = prev_valid;
        end else begin
            adv++;
            if (v) q.push_back('{tag: t, data: refModel(a, b, m, ELEM_W, VEC_W), due: adv + STAGES - 1});
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == adv) begin
                last_tag = q[0].tag;
                last_res = q[0].data;
                exp_v = 1'b1;
                q.delete(0);
            end
        end
        prev_valid = exp_v;
        #1;
        checkOutput("out_valid", 128'(out_valid), 128'(exp_v));
        checkOutput("out_tag", 128'(out_tag), 128'(last_tag));
        checkOutput("result", 128'(result), 128'(last_res));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic doMidReset();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_mid_tag", 128'(out_tag), 128'd0);
        checkOutput("rst_mid_result", 128'(result), 128'd0);
        #3;
        rst_n = 1'b1;
        q.delete();
        adv = 0; prev_valid = 1'b0; last_tag = '0; last_res = '0;
    endtask

    // Count any appearance of the tags that must never be emitted.
    always @(negedge clk) begin
        if (out_valid && out_tag == 7'd9) tag9_seen++;
        if (out_valid && out_tag == 7'd5) tag5_seen++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [0:127] a;
        logic [0:127] b;
        logic [0:127] m16;
        logic [0:63]  e16;
        checks = 0; errors = 0; tag9_seen = 0; tag5_seen = 0;
        adv = 0; prev_valid = 1'b0; last_tag = '0; last_res = '0;
        exp_bound[1] = {32'hF0000000, 32'h00000000, 32'h00000000, 32'h00000000};
        exp_bound[2] = {32'hF0000000, 32'h00000001, 32'h00000000, 32'h00000000};
        exp_bound[3] = {32'hF0000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        #2;
        checkOutput("reset_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_tag", 128'(out_tag), 128'd0);
        checkOutput("reset_result", 128'(result), 128'd0);
        checkOutput("reset_valid16", 128'(out_valid2), 128'd0);
        #4;
        rst_n = 1'b1;

        $display("[TB] rotate defaults");
        a = {32'h80000001, 32'h12345678, 32'h0, 32'h0};
        b = {32'd4, 32'd36, 32'd0, 32'd0};
        applyStimulus(1'b1, 2'b00, 7'h11, a, b, 1'b0, 1'b0);
        checkOutput("rot_latency_early", 128'(out_valid), 128'd0);
        idle(1);
        checkOutput("rot_latency", 128'(out_valid), 128'd1);
        checkOutput("rot_lane0", 128'(result[0:31]), 128'h00000018);
        checkOutput("rot_lane1", 128'(result[32:63]), 128'h23456781);
        checkOutput("rot_tag", 128'(out_tag), 128'h11);

        $display("[TB] shift boundaries");
        a = {4{32'hF0000000}};
        b = {32'd0, 32'd31, 32'd32, 32'd63};
        for (int m = 1; m <= 3; m++) begin
            applyStimulus(1'b1, 2'(m), 7'(20 + m), a, b, 1'b0, 1'b0);
            idle(1);
            checkOutput("bound_result", 128'(result), 128'(exp_bound[m]));
        end

        $display("[TB] stall");
        applyStimulus(1'b1, 2'b00, 7'd1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 7'd2, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 2'b01, 7'd9, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b10, 7'd3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        idle(3);

        $display("[TB] flush");
        applyStimulus(1'b1, 2'b00, 7'd40, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 7'd41, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 7'd5, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        idle(3);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 2'b00, 7'd50, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 7'd51, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        doMidReset();
        idle(4);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, 2'($urandom), 7'($urandom_range(10, 127)),
                          {$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom},
                          ($urandom % 8) == 0, ($urandom % 20) == 0);
        end
        idle(4);
        checkOutput("drain_empty", 128'(q.size()), 128'd0);
        checkOutput("tag9_never", 128'(tag9_seen), 128'd0);
        checkOutput("tag5_never", 128'(tag5_seen), 128'd0);

        $display("[TB] ELEM_W=16 STAGES=1");
        ra2 = {16'h8001, 16'h1234, 16'hF00F, 16'h8000};
        rb2 = {16'd17, 16'd3, 16'd20, 16'd31};
        m2 = 2'b00; t2 = 7'h42; v2 = 1'b1;
        m16 = refModel({ra2, 64'h0}, {rb2, 64'h0}, 2'b00, 16, 64);
        e16 = m16[0:63];
        @(posedge clk);
        #1;
        v2 = 1'b0;
        checkOutput("w16_latency", 128'(out_valid2), 128'd1);
        checkOutput("w16_tag", 128'(out_tag2), 128'h42);
        checkOutput("w16_lane0", 128'(result2[0:15]), 128'h0003);
        checkOutput("w16_vector", 128'(result2), 128'(e16));
        @(posedge clk);
        #1;
        checkOutput("w16_bubble_valid", 128'(out_valid2), 128'd0);
        checkOutput("w16_bubble_hold", 128'(result2[0:15]), 128'h0003);

`ifdef FX2_ROTSH_IMM_EN
        $display("[TB] immediate count");
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {32'd8, 32'd8, 32'd8, 32'd8};
        m16 = refModel(a, b, 2'b00, ELEM_W, VEC_W);
        ra = a; rb = {$urandom, $urandom, $urandom, $urandom};
        in_mode = 2'b00; in_tag = 7'd77; in_use_imm = 1'b1; in_imm = 6'd8;
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_use_imm = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("imm_valid", 128'(out_valid), 128'd1);
        checkOutput("imm_result", 128'(result), 128'(m16));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
